mem_io_responder: RTL
=====================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data and address width.
REQ-002 SHALL have parameter RAM_WORDS, default 1024, meaning depth of the internal RAM.
REQ-003 SHALL have parameter PRESCALE, default 50000, meaning clocks per timer tick (1 ms at 50 MHz).
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have port mem_addr, input, WIDTH, meaning the word address from the CPU.
REQ-007 SHALL have port writedata, input, WIDTH, meaning the CPU write data.
REQ-008 SHALL have port MEM_WR_S, input, 1, meaning the CPU write enable.
REQ-009 SHALL have port mem_out, output, WIDTH, meaning registered read data to the CPU.
REQ-010 SHALL have port sw, input, 10, meaning asynchronous board switches.
REQ-011 SHALL have port btn, input, 1, meaning asynchronous push button, active-high.
REQ-012 SHALL have port led, output, 10, meaning the LED register.

Function
REQ-013 SHALL decode RAM at 0x0000 to RAM_WORDS-1 and I/O at 0xFF00-0xFF06; all other addresses read 0 and ignore writes.
REQ-014 SHALL present read data on mem_out exactly one clock after mem_addr is sampled, with no wait states.
REQ-015 SHALL perform writes at the rising edge where MEM_WR_S=1, using mem_addr and writedata.
REQ-016 SHALL return old data on a read during a write to the same address (read-first).
REQ-017 SHALL decode 0xFF00 SW as read-only: {6'b0, 2-flop-synchronised sw}.
REQ-018 SHALL decode 0xFF01 LED as read/write: bits 9:0 drive led; upper bits are ignored on write and read back as 0.
REQ-019 SHALL decode 0xFF02 BTN_FLAG: bit0 sets on a rising edge of the synchronised btn, and writing 1 to bit0 clears it.
REQ-020 SHALL give set priority over clear when a BTN_FLAG set and clear occur in the same cycle.
REQ-021 SHALL decode 0xFF03 TIMER_COUNT as read-only: increments once per PRESCALE clocks while enabled, and wraps from 0xFFFF to 0x0000.
REQ-022 SHALL decode 0xFF04 TIMER_CMP as read/write.
REQ-023 SHALL decode 0xFF05 TIMER_CTRL: bit0 is enable (read/write); writing bit1=1 zeroes the count and the prescaler in that cycle; bit1 reads as 0.
REQ-024 SHALL decode 0xFF06 TIMER_FLAG: bit0 sets on the tick where the count becomes equal to TIMER_CMP, and writing 1 to bit0 clears it.
REQ-025 SHALL give set priority over clear when a TIMER_FLAG set and clear occur in the same cycle.
REQ-026 SHALL give a TIMER_CTRL count-clear priority over a same-cycle tick.
REQ-027 SHALL reset the prescaler to 0 on each tick, and SHALL hold the prescaler while the timer is disabled.
REQ-028 SHALL NOT give any register a read side effect, so that a multi-cycle CPU hold of an address is safe.

Reset
REQ-029 SHALL clear mem_out, led, BTN_FLAG, TIMER_COUNT, the prescaler, enable, TIMER_FLAG and the synchronisers to 0, and SHALL set TIMER_CMP to 0xFFFF.
REQ-030 SHALL leave RAM contents unchanged on reset.
REQ-031 SHALL abort any operation in progress on reset, with no write committed in the reset cycle.

Structure
REQ-032 SHALL place the address-map constants (RAM_TOP, IO_BASE, register offsets) in the shared package mmio_pkg.
REQ-033 SHALL use sub-module mmio_timer for the prescaler, count, compare and flag logic.
REQ-034 SHALL infer RAM as single-port synchronous block RAM.

Verification
REQ-035 SHALL test: write 0x1234 to 0x0010, then read 0x0010 -> mem_out=0x1234 one clock after the read address is sampled.
REQ-036 SHALL test: write 0x03FF to 0xFF01 -> led=10'h3FF; then read 0xFF01 -> 0x03FF; then read 0x8000 -> 0x0000.
REQ-037 SHALL test: pulse btn high for 3 clocks -> BTN_FLAG reads 1 about 3 clocks later; write 0x0001 -> reads 0; an edge coinciding with the clear -> reads 1.
REQ-038 SHALL test: PRESCALE=4, CMP=3, CTRL=1 -> COUNT reaches 3 after 12 clocks and TIMER_FLAG=1; writing CTRL=3 -> COUNT=0.
REQ-039 SHALL test: CMP=0xFFFF, force count 0xFFFF -> next tick COUNT=0x0000 and no extra flag set.
REQ-040 SHALL test: assert reset mid-write to 0xFF01 -> led=0, TIMER_CMP=0xFFFF, mem_out=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Address map shared by the memory/IO responder and its timer.
// RAM sits at the bottom of the space, seven IO registers at IO_BASE.
package mmio_pkg;

  localparam int RAM_TOP = 1023;
  localparam logic [15:0] IO_BASE = 16'hFF00;

  localparam logic [2:0] OFF_SW    = 3'd0;
  localparam logic [2:0] OFF_LED   = 3'd1;
  localparam logic [2:0] OFF_BTN   = 3'd2;
  localparam logic [2:0] OFF_CNT   = 3'd3;
  localparam logic [2:0] OFF_CMP   = 3'd4;
  localparam logic [2:0] OFF_CTRL  = 3'd5;
  localparam logic [2:0] OFF_TFLAG = 3'd6;
  localparam logic [2:0] OFF_LAST  = OFF_TFLAG;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_IO
  } sel_e;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled up-counter with compare flag.
// A count clear beats a same-cycle tick; a flag set beats a same-cycle clear.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmp_we,
  input  logic             ctrl_we,
  input  logic             flag_clr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] cmp,
  output logic             enable,
  output logic             flag
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] count_inc;
  logic             clear;
  logic             tick;

  assign clear     = ctrl_we & wdata[1];
  assign tick      = enable & (pre == PRE_LAST);
  assign count_inc = count + WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre    <= '0;
      count  <= '0;
      cmp    <= '1;
      enable <= 1'b0;
      flag   <= 1'b0;
    end else begin
      if (cmp_we)
        cmp <= wdata;
      if (ctrl_we)
        enable <= wdata[0];
      if (clear) begin
        pre   <= '0;
        count <= '0;
      end else if (tick) begin
        pre   <= '0;
        count <= count_inc;
      end else if (enable) begin
        pre <= pre + PW'(1);
      end
      flag <= (tick & ~clear & (count_inc == cmp))
            | (flag & ~flag_clr);
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Zero-wait-state RAM plus memory-mapped switches, LEDs, button and timer.
// Read data is registered; RAM contents survive reset.
module mem_io_responder
  import mmio_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RAM_WORDS = RAM_TOP + 1,
  parameter int PRESCALE  = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             MEM_WR_S,
  output logic [WIDTH-1:0] mem_out,
  input  logic [9:0]       sw,
  input  logic             btn,
  output logic [9:0]       led
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [WIDTH-1:0] ram [RAM_WORDS];
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] io_d;
  logic [WIDTH-1:0] io_q;
  logic [WIDTH-1:0] off;
  logic [AW-1:0]    idx;
  logic [2:0]       reg_sel;
  logic             is_ram;
  logic             is_io;
  sel_e             sel_d;
  sel_e             sel_q;

  logic [9:0] sw_s1;
  logic [9:0] sw_s2;
  logic       btn_s1;
  logic       btn_s2;
  logic       btn_s3;
  logic       btn_flag;

  logic             wr_led;
  logic             wr_btn;
  logic             wr_cmp;
  logic             wr_ctrl;
  logic             wr_tflag;
  logic [WIDTH-1:0] t_count;
  logic [WIDTH-1:0] t_cmp;
  logic             t_en;
  logic             t_flag;

  assign is_ram  = mem_addr < WIDTH'(RAM_WORDS);
  assign off     = mem_addr - WIDTH'(IO_BASE);
  assign is_io   = (mem_addr >= WIDTH'(IO_BASE))
                 & (off <= WIDTH'(OFF_LAST));
  assign idx     = mem_addr[AW-1:0];
  assign reg_sel = off[2:0];

  assign wr_led   = MEM_WR_S & is_io & (reg_sel == OFF_LED);
  assign wr_btn   = MEM_WR_S & is_io & (reg_sel == OFF_BTN);
  assign wr_cmp   = MEM_WR_S & is_io & (reg_sel == OFF_CMP);
  assign wr_ctrl  = MEM_WR_S & is_io & (reg_sel == OFF_CTRL);
  assign wr_tflag = MEM_WR_S & is_io & (reg_sel == OFF_TFLAG);

  // Read-first single-port RAM; reset blocks the write, not the array.
  always_ff @(posedge clk) begin
    if (MEM_WR_S && is_ram && !reset)
      ram[idx] <= writedata;
    ram_q <= ram[idx];
  end

  always_comb begin
    io_d = '0;
    if (is_io) begin
      case (reg_sel)
        OFF_SW:    io_d = WIDTH'(sw_s2);
        OFF_LED:   io_d = WIDTH'(led);
        OFF_BTN:   io_d = WIDTH'(btn_flag);
        OFF_CNT:   io_d = t_count;
        OFF_CMP:   io_d = t_cmp;
        OFF_CTRL:  io_d = WIDTH'(t_en);
        OFF_TFLAG: io_d = WIDTH'(t_flag);
        default:   io_d = '0;
      endcase
    end
  end

  always_comb begin
    sel_d = SEL_NONE;
    if (is_ram)
      sel_d = SEL_RAM;
    else if (is_io)
      sel_d = SEL_IO;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= SEL_NONE;
      io_q     <= '0;
      led      <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_s3   <= 1'b0;
      btn_flag <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      io_q   <= io_d;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      if (wr_led)
        led <= writedata[9:0];
      btn_flag <= (btn_s2 & ~btn_s3)
                | (btn_flag & ~(wr_btn & writedata[0]));
    end
  end

  always_comb begin
    unique case (sel_q)
      SEL_RAM: mem_out = ram_q;
      SEL_IO:  mem_out = io_q;
      default: mem_out = '0;
    endcase
  end

  mmio_timer #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .cmp_we   (wr_cmp),
    .ctrl_we  (wr_ctrl),
    .flag_clr (wr_tflag & writedata[0]),
    .wdata    (writedata),
    .count    (t_count),
    .cmp      (t_cmp),
    .enable   (t_en),
    .flag     (t_flag)
  );

endmodule
